// File: rtl/conv3_buf_sched.sv
// Write/read scheduler for the conv3 output line buffer (circular RAM of MEM_ROWS rows).
// Define CONV3_BUF_SCHED_PERF_EN to add the wr_stall_cnt/rd_wait_cnt performance counters.
module conv3_buf_sched #(
   parameter int unsigned LENGTH   = 18,
   parameter int unsigned HEIGHT   = 57,
   parameter int unsigned FILTER   = 2,
   parameter int unsigned STRIDE   = 2,
   parameter int unsigned MEM_ROWS = 4,
   parameter int unsigned ADDR_W   = 9,
   parameter int unsigned CNT_W    = 7
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic              win_first,
   output logic              win_last,
   output logic              frame_done
`ifdef CONV3_BUF_SCHED_PERF_EN
   ,
   output logic [15:0]       wr_stall_cnt,
   output logic [15:0]       rd_wait_cnt
`endif
);

   localparam int unsigned PrW = (MEM_ROWS > 1) ? $clog2(MEM_ROWS) : 1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [CNT_W:0]   cnt_x_t;
   typedef logic [PrW-1:0]   prow_t;
   typedef logic [PrW:0]     prow_sum_t;

   localparam cnt_t      CntOne     = cnt_t'(1);
   localparam cnt_t      ColLast    = cnt_t'(LENGTH - 1);
   localparam cnt_t      RowsTotal  = cnt_t'(HEIGHT);
   localparam cnt_t      WinLast    = cnt_t'((LENGTH - FILTER) / STRIDE);
   localparam cnt_t      OutRowLast = cnt_t'((HEIGHT - FILTER) / STRIDE);
   localparam cnt_t      OffLast    = cnt_t'(FILTER - 1);
   localparam cnt_t      StrideCnt  = cnt_t'(STRIDE);
   localparam cnt_x_t    MemRowsX   = cnt_x_t'(MEM_ROWS);
   localparam cnt_x_t    OffLastX   = cnt_x_t'(FILTER - 1);
   localparam prow_t     PrOne      = prow_t'(1);
   localparam prow_t     PrLast     = prow_t'(MEM_ROWS - 1);
   localparam prow_sum_t MemRowsP   = prow_sum_t'(MEM_ROWS);
   localparam prow_sum_t StrideP    = prow_sum_t'(STRIDE);

   typedef enum logic [1:0] {StIdle, StWait, StRead, StDone} rd_state_e;

   function automatic logic [ADDR_W-1:0] row_addr(input prow_t prow, input cnt_t col);
      return ADDR_W'(prow) * ADDR_W'(LENGTH) + ADDR_W'(col);
   endfunction

   // Sums never exceed 2*MEM_ROWS-1, so one conditional subtract is a full modulo.
   function automatic prow_t prow_wrap(input prow_sum_t sum);
      return (sum >= MemRowsP) ? prow_t'(sum - MemRowsP) : prow_t'(sum);
   endfunction

   rd_state_e state_q, state_d;
   cnt_t      wr_row_q, wr_row_d;
   cnt_t      wr_col_q, wr_col_d;
   prow_t     wr_prow_q, wr_prow_d;
   cnt_t      rel_row_q, rel_row_d;
   prow_t     rel_prow_q, rel_prow_d;
   cnt_t      out_row_q, out_row_d;
   cnt_t      win_q, win_d;
   cnt_t      dr_q, dr_d;
   cnt_t      dc_q, dc_d;
   logic      rd_valid_q, rd_valid_d;
   logic      win_first_q, win_first_d;
   logic      win_last_q, win_last_d;
   logic      frame_done_q, frame_done_d;
   logic      clear;
   logic      elem_last;
   prow_t     rd_prow;
   cnt_t      rd_col;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_row_q     <= '0;
         wr_col_q     <= '0;
         wr_prow_q    <= '0;
         rel_row_q    <= '0;
         rel_prow_q   <= '0;
         out_row_q    <= '0;
         win_q        <= '0;
         dr_q         <= '0;
         dc_q         <= '0;
         rd_valid_q   <= 1'b0;
         win_first_q  <= 1'b0;
         win_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_row_q     <= wr_row_d;
         wr_col_q     <= wr_col_d;
         wr_prow_q    <= wr_prow_d;
         rel_row_q    <= rel_row_d;
         rel_prow_q   <= rel_prow_d;
         out_row_q    <= out_row_d;
         win_q        <= win_d;
         dr_q         <= dr_d;
         dc_q         <= dc_d;
         rd_valid_q   <= rd_valid_d;
         win_first_q  <= win_first_d;
         win_last_q   <= win_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Write side: held off until the scheduler leaves IDLE, then bounded by the oldest live row.
   always_comb begin
      in_ready  = (state_q != StIdle)
                  && ({1'b0, wr_row_q} < ({1'b0, rel_row_q} + MemRowsX))
                  && (wr_row_q < RowsTotal);
      wr_en     = in_valid && in_ready;
      wr_addr   = row_addr(wr_prow_q, wr_col_q);
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      wr_prow_d = wr_prow_q;
      if (clear) begin
         wr_row_d  = '0;
         wr_col_d  = '0;
         wr_prow_d = '0;
      end else if (wr_en) begin
         if (wr_col_q == ColLast) begin
            wr_col_d  = '0;
            wr_row_d  = wr_row_q + CntOne;
            wr_prow_d = (wr_prow_q == PrLast) ? '0 : wr_prow_q + PrOne;
         end else begin
            wr_col_d = wr_col_q + CntOne;
         end
      end
   end

   always_comb begin
      rd_prow = prow_wrap({1'b0, rel_prow_q} + prow_sum_t'(dr_q));
      rd_col  = win_q * StrideCnt + dc_q;
      rd_addr = row_addr(rd_prow, rd_col);
   end

   // Read FSM: element order is column offset outer, row offset inner.
   always_comb begin
      state_d      = state_q;
      rel_row_d    = rel_row_q;
      rel_prow_d   = rel_prow_q;
      out_row_d    = out_row_q;
      win_d        = win_q;
      dr_d         = dr_q;
      dc_d         = dc_q;
      rd_valid_d   = 1'b0;
      win_first_d  = 1'b0;
      win_last_d   = 1'b0;
      frame_done_d = 1'b0;
      clear        = 1'b0;
      elem_last    = (dr_q == OffLast) && (dc_q == OffLast);
      unique case (state_q)
         StIdle: state_d = StWait;
         StWait: begin
            if ({1'b0, wr_row_q} > ({1'b0, rel_row_q} + OffLastX)) begin
               state_d = StRead;
            end
         end
         StRead: begin
            if (out_ready) begin
               rd_valid_d  = 1'b1;
               win_first_d = (dr_q == '0) && (dc_q == '0);
               win_last_d  = elem_last;
               if (elem_last) begin
                  dr_d = '0;
                  dc_d = '0;
                  if (win_q == WinLast) begin
                     win_d      = '0;
                     out_row_d  = out_row_q + CntOne;
                     rel_row_d  = rel_row_q + StrideCnt;
                     rel_prow_d = prow_wrap({1'b0, rel_prow_q} + StrideP);
                     state_d    = (out_row_q == OutRowLast) ? StDone : StWait;
                  end else begin
                     win_d = win_q + CntOne;
                  end
               end else if (dr_q == OffLast) begin
                  dr_d = '0;
                  dc_d = dc_q + CntOne;
               end else begin
                  dr_d = dr_q + CntOne;
               end
            end
         end
         StDone: begin
            if (wr_row_q == RowsTotal) begin
               frame_done_d = 1'b1;
               clear        = 1'b1;
               rel_row_d    = '0;
               rel_prow_d   = '0;
               out_row_d    = '0;
               win_d        = '0;
               dr_d         = '0;
               dc_d         = '0;
               state_d      = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rd_valid   = rd_valid_q;
   assign win_first  = win_first_q;
   assign win_last   = win_last_q;
   assign frame_done = frame_done_q;

`ifdef CONV3_BUF_SCHED_PERF_EN
   logic [15:0] wr_stall_q, wr_stall_d;
   logic [15:0] rd_wait_q, rd_wait_d;

   // Cleared after the frame_done pulse so the totals can be captured alongside it.
   always_comb begin
      wr_stall_d = wr_stall_q;
      rd_wait_d  = rd_wait_q;
      if (frame_done_q) begin
         wr_stall_d = '0;
         rd_wait_d  = '0;
      end else begin
         if (in_valid && !in_ready && (wr_stall_q != 16'hFFFF)) begin
            wr_stall_d = wr_stall_q + 16'd1;
         end
         if ((state_q == StWait) && (rd_wait_q != 16'hFFFF)) begin
            rd_wait_d = rd_wait_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         wr_stall_q <= '0;
         rd_wait_q  <= '0;
      end else begin
         wr_stall_q <= wr_stall_d;
         rd_wait_q  <= rd_wait_d;
      end
   end

   assign wr_stall_cnt = wr_stall_q;
   assign rd_wait_cnt  = rd_wait_q;
`endif

endmodule

// File: tb/tb_conv3_buf_sched.sv
// Bench for conv3_buf_sched: models the line-buffer RAM and checks window data/order,
// back-pressure and frame framing against a reference built from nested window loops.
module tb_conv3_buf_sched;

   localparam int LENGTH      = 18;
   localparam int HEIGHT      = 57;
   localparam int FILTER      = 2;
   localparam int STRIDE      = 2;
   localparam int MEM_ROWS    = 4;
   localparam int ADDR_W      = 9;
   localparam int OUT_ROWS    = (HEIGHT - FILTER) / STRIDE + 1;
   localparam int WINS        = (LENGTH - FILTER) / STRIDE + 1;
   localparam int ELEMS       = FILTER * FILTER;
   localparam int ROW_READS   = WINS * ELEMS;
   localparam int FRAME_READS = OUT_ROWS * ROW_READS;
   localparam int FRAME_PIX   = LENGTH * HEIGHT;

   logic              clk_in = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              out_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic              win_first;
   logic              win_last;
   logic              frame_done;
`ifdef CONV3_BUF_SCHED_PERF_EN
   logic [15:0]       wr_stall_cnt;
   logic [15:0]       rd_wait_cnt;
`endif

   always #5 clk_in = ~clk_in;

   conv3_buf_sched dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .out_ready  (out_ready),
      .rd_addr    (rd_addr),
      .rd_valid   (rd_valid),
      .win_first  (win_first),
      .win_last   (win_last),
      .frame_done (frame_done)
`ifdef CONV3_BUF_SCHED_PERF_EN
      ,
      .wr_stall_cnt (wr_stall_cnt),
      .rd_wait_cnt  (rd_wait_cnt)
`endif
   );

   // Line-buffer RAM with 1-cycle read latency; data word = {frame tag, pixel index}.
   logic [15:0]       mem [0:(1<<ADDR_W)-1];
   logic [15:0]       wdata;
   logic [15:0]       rd_data;
   logic [ADDR_W-1:0] rd_addr_q;

   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_addr] <= wdata;
      rd_data   <= mem[rd_addr];
      rd_addr_q <= rd_addr;
   end

   int       exp_pix  [FRAME_READS];
   int       exp_addr [FRAME_READS];
   int       vectors = 0;
   int       fails = 0;
   int       writes = 0;
   int       writes_before = 0;
   int       rd_idx = 0;
   int       rows_done = 0;
   int       firsts = 0;
   int       frames = 0;
   logic [3:0] tag = 4'd1;
   bit       idle = 1'b1;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_restart();
      writes    = 0;
      rd_idx    = 0;
      rows_done = 0;
      firsts    = 0;
      tag       = tag + 4'd1;
      idle      = 1'b1;
   endtask

   task automatic check_reset_outs();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_win_flags", {win_first, win_last}, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);
   endtask

   // Called #1 after each active edge.
   task automatic observe();
      if (rd_valid) begin
         chk("rd_in_frame", rd_idx < FRAME_READS, 1);
         if (rd_idx < FRAME_READS) begin
            chk("rd_data", rd_data, {tag, 12'(exp_pix[rd_idx])});
            chk("rd_addr", rd_addr_q, exp_addr[rd_idx]);
            chk("win_first", win_first, (rd_idx % ELEMS) == 0);
            chk("win_last", win_last, (rd_idx % ELEMS) == ELEMS - 1);
            if ((rd_idx % ROW_READS) == 0)
               chk("rows_ready", writes_before >= ((rd_idx / ROW_READS) * STRIDE + FILTER) * LENGTH, 1);
         end
         if (win_first) firsts++;
         rd_idx++;
         if ((rd_idx % ROW_READS) == 0) rows_done++;
      end else begin
         chk("flags_no_valid", {win_first, win_last}, 0);
      end
      if (frame_done) begin
         chk("fd_writes", writes, FRAME_PIX);
         chk("fd_reads", rd_idx, FRAME_READS);
         chk("fd_firsts", firsts, OUT_ROWS * WINS);
         frames++;
         writes    = 0;
         rd_idx    = 0;
         rows_done = 0;
         firsts    = 0;
         tag       = tag + 4'd1;
      end
   endtask

   task automatic step(input logic iv, input logic ordy);
      bit exp_rdy;
      in_valid  = iv;
      out_ready = ordy;
      wdata     = {tag, 12'(writes)};
      #1;
      exp_rdy = (writes < FRAME_PIX) && ((writes / LENGTH) < rows_done * STRIDE + MEM_ROWS);
      if (!idle) begin
         chk("in_ready", in_ready, exp_rdy);
         chk("wr_en", wr_en, iv && exp_rdy);
      end
      writes_before = writes;
      if (wr_en) begin
         chk("wr_addr", wr_addr, ((writes / LENGTH) % MEM_ROWS) * LENGTH + writes % LENGTH);
         writes++;
      end
      @(posedge clk_in);
      #1;
      idle = 1'b0;
      observe();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check_reset_outs();
      rst = 1'b0;
      model_restart();
   endtask

   task automatic async_reset_mid();
      #3;
      rst = 1'b1;
      #1;
      check_reset_outs();
      @(posedge clk_in);
      #1;
      rst = 1'b0;
      model_restart();
   endtask

   // mode 0: in_valid=1/out_ready=1; mode 1: out_ready toggles; mode 2: random both.
   task automatic run_frame(input int mode, input int bound);
      int start;
      int n;
      start = frames;
      n = 0;
      while (frames == start && n < bound) begin
         case (mode)
            0:       step(1'b1, 1'b1);
            1:       step(1'b1, (n % 2) == 0);
            default: step($urandom_range(3) != 0, $urandom_range(1) == 1);
         endcase
         n++;
      end
      chk("frame_done_seen", frames - start, 1);
   endtask

   initial begin
      int n;
      n = 0;
      for (int r = 0; r < OUT_ROWS; r++)
         for (int wc = 0; wc < WINS; wc++)
            for (int dc = 0; dc < FILTER; dc++)
               for (int dr = 0; dr < FILTER; dr++) begin
                  exp_pix[n]  = (r * STRIDE + dr) * LENGTH + wc * STRIDE + dc;
                  exp_addr[n] = ((r * STRIDE + dr) % MEM_ROWS) * LENGTH + wc * STRIDE + dc;
                  n++;
               end
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      wdata     = '0;

      // Continuous flow, full frame.
      do_reset();
      run_frame(0, 4000);

      // No reads: writes must stop after MEM_ROWS rows.
      do_reset();
      repeat (200) step(1'b1, 1'b0);
      chk("stall_writes", writes, MEM_ROWS * LENGTH);
      chk("stall_reads", rd_idx, 0);

      // Reader accepts every other cycle.
      do_reset();
      run_frame(1, 8000);

      // Asynchronous reset mid-frame, then a clean frame.
      do_reset();
      for (int i = 0; i < 3000 && writes < 500; i++) step(1'b1, 1'b1);
      chk("pre_rst_writes", writes, 500);
      async_reset_mid();
      repeat (5) step(1'b0, 1'b1);
      chk("no_residual_reads", rd_idx, 0);
      run_frame(0, 4000);

      // Random valid/ready.
      do_reset();
      run_frame(2, 20000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
